// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch (read-only) and the data port.
// Data port wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive data wins over a waiting fetch. One transaction in flight at a time.
// Optional: define ARB_TIMEOUT_EN to enable a read-response watchdog (TIMEOUT_CYCLES).
module mem_port_arbiter #(
   parameter int unsigned AW             = 32,
   parameter int unsigned DW             = 32,
   parameter int unsigned STARVE_LIMIT   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_if_req,
   input  logic [AW-1:0]   i_if_addr,
   output logic            o_if_gnt,
   output logic            o_if_rvalid,
   output logic [DW-1:0]   o_if_rdata,
   input  logic            i_dm_req,
   input  logic            i_dm_we,
   input  logic [AW-1:0]   i_dm_addr,
   input  logic [DW-1:0]   i_dm_wdata,
   input  logic [DW/8-1:0] i_dm_be,
   output logic            o_dm_gnt,
   output logic            o_dm_rvalid,
   output logic [DW-1:0]   o_dm_rdata,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [AW-1:0]   o_mem_addr,
   output logic [DW-1:0]   o_mem_wdata,
   output logic [DW/8-1:0] o_mem_be,
   input  logic            i_mem_ready,
   input  logic            i_mem_rvalid,
   input  logic [DW-1:0]   i_mem_rdata,
   output logic            o_err
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e          state_q;
   logic            owner_dm_q;
   logic            we_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [BW-1:0]   be_q;
   logic [SW-1:0]   starve_cnt_q;
   logic            if_rvalid_q;
   logic            dm_rvalid_q;
   logic [DW-1:0]   if_rdata_q;
   logic [DW-1:0]   dm_rdata_q;

   logic            force_if;
   logic            dm_win;
   logic            if_win;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]   tmo_cnt_q;
   logic            err_q;
`endif

   // Winner selection: data port first unless the fetch side has waited too long.
   always_comb begin
      force_if = i_if_req && (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX);
      dm_win   = i_dm_req && !force_if;
      if_win   = i_if_req && !dm_win;
   end

   assign o_if_gnt    = (state_q == StIdle) && if_win;
   assign o_dm_gnt    = (state_q == StIdle) && dm_win;
   assign o_mem_req   = (state_q == StReq);
   assign o_mem_we    = we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_be    = be_q;
   assign o_if_rvalid = if_rvalid_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_dm_rvalid = dm_rvalid_q;
   assign o_dm_rdata  = dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
   assign o_err       = err_q;
`else
   assign o_err       = 1'b0;
`endif

   // Arbitration FSM: capture winner, drive the bus, route the read response back.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= StIdle;
         owner_dm_q   <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         starve_cnt_q <= '0;
         if_rvalid_q  <= 1'b0;
         dm_rvalid_q  <= 1'b0;
         if_rdata_q   <= '0;
         dm_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         // Response strobes are single-cycle pulses.
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
         case (state_q)
            StIdle: begin
               if (o_dm_gnt) begin
                  owner_dm_q <= 1'b1;
                  we_q       <= i_dm_we;
                  addr_q     <= i_dm_addr;
                  wdata_q    <= i_dm_wdata;
                  be_q       <= i_dm_be;
                  state_q    <= StReq;
                  // Count only wins that actually kept a fetch waiting.
                  if (i_if_req && (starve_cnt_q != STARVE_MAX)) begin
                     starve_cnt_q <= starve_cnt_q + 1'b1;
                  end
               end else if (o_if_gnt) begin
                  owner_dm_q   <= 1'b0;
                  we_q         <= 1'b0;
                  addr_q       <= i_if_addr;
                  wdata_q      <= '0;
                  be_q         <= '1;
                  state_q      <= StReq;
                  starve_cnt_q <= '0;
               end
            end
            StReq: begin
               if (i_mem_ready) begin
                  state_q <= we_q ? StIdle : StWait;
`ifdef ARB_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end
            end
            StWait: begin
               if (i_mem_rvalid) begin
                  if (owner_dm_q) begin
                     dm_rdata_q  <= i_mem_rdata;
                     dm_rvalid_q <= 1'b1;
                  end else begin
                     if_rdata_q  <= i_mem_rdata;
                     if_rvalid_q <= 1'b1;
                  end
                  state_q <= StIdle;
               end
`ifdef ARB_TIMEOUT_EN
               else if (tmo_cnt_q == TMO_LAST) begin
                  // Give up: return zero data so the requester is not stuck.
                  err_q <= 1'b1;
                  if (owner_dm_q) begin
                     dm_rdata_q  <= '0;
                     dm_rvalid_q <= 1'b1;
                  end else begin
                     if_rdata_q  <= '0;
                     if_rvalid_q <= 1'b1;
                  end
                  state_q <= StIdle;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants, bus transactions
// and read responses into queues; a monitor pops and compares as the DUT presents them.
module tb_mem_port_arbiter;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_t;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_gnt;
   logic        o_if_rvalid;
   logic [31:0] o_if_rdata;
   logic        i_dm_req;
   logic        i_dm_we;
   logic [31:0] i_dm_addr;
   logic [31:0] i_dm_wdata;
   logic [3:0]  i_dm_be;
   logic        o_dm_gnt;
   logic        o_dm_rvalid;
   logic [31:0] o_dm_rdata;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_be;
   logic        i_mem_ready;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_err;

   int tests_run    = 0;
   int tests_failed = 0;

   bit          gnt_q[$];   // 1 = DM expected, 0 = IF expected
   mem_t        mem_q[$];
   logic [31:0] if_q[$];
   logic [31:0] dm_q[$];
   int          err_pending = 0;

   bit          resp_en   = 1'b1;
   int          resp_lat  = 1;
   logic [31:0] resp_data = '0;

   mem_port_arbiter #(
      .AW(32), .DW(32), .STARVE_LIMIT(3), .TIMEOUT_CYCLES(8)
   ) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
      .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
      .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
      .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be), .o_dm_gnt(o_dm_gnt),
      .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be), .i_mem_ready(i_mem_ready),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_err(o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic mem_t mk(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
      mem_t m;
      m.we = we; m.addr = addr; m.wdata = wdata; m.be = be;
      return m;
   endfunction

   task automatic wait_gnt(input bit dm);
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (dm ? o_dm_gnt : o_if_gnt) return;
      end
      chk(dm ? "dm_gnt_timeout" : "if_gnt_timeout", 64'd0, 64'd1);
   endtask

   task automatic dm_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
      i_dm_req = 1'b1; i_dm_we = we; i_dm_addr = addr; i_dm_wdata = wdata; i_dm_be = be;
      wait_gnt(1'b1);
      step();
      i_dm_req = 1'b0;
   endtask

   task automatic if_txn(input logic [31:0] addr);
      i_if_req = 1'b1; i_if_addr = addr;
      wait_gnt(1'b0);
      step();
      i_if_req = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (gnt_q.size() == 0 && mem_q.size() == 0 && if_q.size() == 0 &&
             dm_q.size() == 0 && err_pending == 0) return;
      end
      chk("drain_timeout", 64'(gnt_q.size() + mem_q.size() + if_q.size() + dm_q.size()), 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctrl"}, {o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid, o_mem_req, o_mem_we,
                           o_err}, 64'd0);
      chk({tag, "_addr"}, o_mem_addr, 64'd0);
      chk({tag, "_wdata"}, o_mem_wdata, 64'd0);
      chk({tag, "_be"}, o_mem_be, 64'd0);
      chk({tag, "_if_rdata"}, o_if_rdata, 64'd0);
      chk({tag, "_dm_rdata"}, o_dm_rdata, 64'd0);
   endtask

   // Monitor: compare every grant, bus accept, response and error pulse against the queues.
   initial begin
      mem_t m;
      forever begin
         @(negedge clk);
         if (o_if_gnt && o_dm_gnt) chk("dual_grant", 64'd1, 64'd0);
         if (o_if_gnt || o_dm_gnt) begin
            if (gnt_q.size() == 0) chk("unexpected_grant", {o_if_gnt, o_dm_gnt}, 64'd0);
            else chk("grant_owner", o_dm_gnt, gnt_q.pop_front());
         end
         if (o_mem_req && i_mem_ready) begin
            if (mem_q.size() == 0) chk("unexpected_mem_accept", 64'd1, 64'd0);
            else begin
               m = mem_q.pop_front();
               chk("mem_we", o_mem_we, m.we);
               chk("mem_addr", o_mem_addr, m.addr);
               chk("mem_wdata", o_mem_wdata, m.wdata);
               chk("mem_be", o_mem_be, m.be);
            end
         end
         if (o_if_rvalid) begin
            if (if_q.size() == 0) chk("unexpected_if_rvalid", 64'd1, 64'd0);
            else chk("if_rdata", o_if_rdata, if_q.pop_front());
         end
         if (o_dm_rvalid) begin
            if (dm_q.size() == 0) chk("unexpected_dm_rvalid", 64'd1, 64'd0);
            else chk("dm_rdata", o_dm_rdata, dm_q.pop_front());
         end
         if (o_err) begin
            chk("err_expected", 64'(err_pending > 0), 64'd1);
            if (err_pending > 0) err_pending--;
         end
      end
   end

   // Memory read responder: answers an accepted read resp_lat cycles after accept.
   initial begin
      logic [31:0] d;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (resp_en && o_mem_req && i_mem_ready && !o_mem_we) begin
            d = resp_data;
            repeat (resp_lat) @(posedge clk);
            #1;
            i_mem_rvalid = 1'b1; i_mem_rdata = d;
            @(posedge clk);
            #1;
            i_mem_rvalid = 1'b0; i_mem_rdata = '0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      i_reset = 1'b1; i_if_req = 1'b0; i_if_addr = '0;
      i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_be = '0;
      i_mem_ready = 1'b1;
      @(negedge clk);
      chk_zero("reset");
      step();
      i_reset = 1'b0;

      // DM write: grant in the request cycle, bus one cycle later, idle after accept.
      step();
      gnt_q.push_back(1'b1);
      mem_q.push_back(mk(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF));
      i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h100; i_dm_wdata = 32'hCAFE_F00D;
      i_dm_be = 4'hF;
      @(negedge clk);
      chk("t1_dm_gnt_cycle0", o_dm_gnt, 64'd1);
      chk("t1_memreq_cycle0", o_mem_req, 64'd0);
      step();
      i_dm_req = 1'b0;
      @(negedge clk);
      chk("t1_memreq_cycle1", o_mem_req, 64'd1);
      @(negedge clk);
      chk("t1_memreq_cycle2", o_mem_req, 64'd0);
      drain();

      // IF read with response 2 cycles after accept.
      step();
      resp_lat = 2; resp_data = 32'h0000_0013;
      gnt_q.push_back(1'b0);
      mem_q.push_back(mk(1'b0, 32'h40, 32'h0, 4'hF));
      if_q.push_back(32'h0000_0013);
      if_txn(32'h40);
      drain();

      // Contention: three DM wins over a waiting IF, then IF is forced through.
      step();
      resp_lat = 1; resp_data = 32'h1111_1111;
      gnt_q.push_back(1'b1); gnt_q.push_back(1'b1); gnt_q.push_back(1'b1);
      gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
      mem_q.push_back(mk(1'b1, 32'h200, 32'hA0, 4'hF));
      mem_q.push_back(mk(1'b1, 32'h204, 32'hA1, 4'hF));
      mem_q.push_back(mk(1'b1, 32'h208, 32'hA2, 4'hF));
      mem_q.push_back(mk(1'b0, 32'h80, 32'h0, 4'hF));
      mem_q.push_back(mk(1'b1, 32'h20C, 32'hA3, 4'hF));
      if_q.push_back(32'h1111_1111);
      fork
         if_txn(32'h80);
         for (int k = 0; k < 4; k++) dm_txn(1'b1, 32'h200 + 4 * k, 32'hA0 + k, 4'hF);
      join
      drain();

      // Starvation counter cleared: with both pending again DM wins first.
      step();
      resp_data = 32'h2222_2222;
      gnt_q.push_back(1'b1); gnt_q.push_back(1'b0);
      mem_q.push_back(mk(1'b1, 32'h300, 32'hB0, 4'hF));
      mem_q.push_back(mk(1'b0, 32'h84, 32'h0, 4'hF));
      if_q.push_back(32'h2222_2222);
      fork
         if_txn(32'h84);
         dm_txn(1'b1, 32'h300, 32'hB0, 4'hF);
      join
      drain();

      // Backpressure: DM read held 5 cycles without ready, IF waits through REQ and WAIT.
      step();
      i_mem_ready = 1'b0; resp_data = 32'h0BAD_BEEF;
      gnt_q.push_back(1'b1);
      mem_q.push_back(mk(1'b0, 32'h400, 32'h0, 4'h3));
      dm_q.push_back(32'h0BAD_BEEF);
      i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h400; i_dm_wdata = '0; i_dm_be = 4'h3;
      wait_gnt(1'b1);
      step();
      i_dm_req = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h44;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_mem_req", o_mem_req, 64'd1);
         chk("bp_mem_addr", o_mem_addr, 64'h400);
         chk("bp_mem_we_be", {o_mem_we, o_mem_be}, 64'h03);
         chk("bp_no_if_gnt_req", o_if_gnt, 64'd0);
      end
      step();
      i_mem_ready = 1'b1;
      @(negedge clk);
      chk("bp_no_if_gnt_accept", o_if_gnt, 64'd0);
      step();
      resp_data = 32'h4444_4444;
      gnt_q.push_back(1'b0);
      mem_q.push_back(mk(1'b0, 32'h44, 32'h0, 4'hF));
      if_q.push_back(32'h4444_4444);
      @(negedge clk);
      chk("bp_no_if_gnt_wait", o_if_gnt, 64'd0);
      chk("bp_wait_no_memreq", o_mem_req, 64'd0);
      if_txn(32'h44);
      drain();

      // Reset during a pending IF read: response after release must be dropped.
      step();
      resp_en = 1'b0;
      gnt_q.push_back(1'b0);
      mem_q.push_back(mk(1'b0, 32'h48, 32'h0, 4'hF));
      if_txn(32'h48);
      @(negedge clk);
      @(negedge clk);
      step();
      i_reset = 1'b1;
      @(negedge clk);
      chk_zero("midreset");
      step();
      i_reset = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rst_no_if_rvalid0", o_if_rvalid, 64'd0);
      step();
      i_mem_rvalid = 1'b0; i_mem_rdata = '0;
      @(negedge clk);
      chk("rst_no_if_rvalid1", o_if_rvalid, 64'd0);
      chk("rst_if_rdata", o_if_rdata, 64'd0);
      step();
      resp_en = 1'b1;
      gnt_q.push_back(1'b1);
      mem_q.push_back(mk(1'b1, 32'h600, 32'h600D_0001, 4'hC));
      i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h600; i_dm_wdata = 32'h600D_0001;
      i_dm_be = 4'hC;
      @(negedge clk);
      chk("rst_next_gnt", o_dm_gnt, 64'd1);
      step();
      i_dm_req = 1'b0;
      drain();

`ifdef ARB_TIMEOUT_EN
      // Watchdog: read accepted, memory never answers.
      step();
      resp_en = 1'b0;
      gnt_q.push_back(1'b1);
      mem_q.push_back(mk(1'b0, 32'h500, 32'h0, 4'hF));
      dm_q.push_back(32'h0);
      err_pending = 1;
      dm_txn(1'b0, 32'h500, 32'h0, 4'hF);
      @(negedge clk);
      n = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (o_err) begin
            n = k;
            break;
         end
      end
      chk("tmo_latency", 64'(n), 64'd9);
      chk("tmo_dm_rvalid", o_dm_rvalid, 64'd1);
      @(negedge clk);
      chk("tmo_err_pulse", o_err, 64'd0);
      chk("tmo_idle", o_mem_req, 64'd0);
      resp_en = 1'b1;
      drain();
`endif

      chk("end_gnt_q", 64'(gnt_q.size()), 64'd0);
      chk("end_mem_q", 64'(mem_q.size()), 64'd0);
      chk("end_rsp_q", 64'(if_q.size() + dm_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory port between the instruction-fetch requester (IF, read-only) and the data-memory requester (DM, read/write).
- Sits between the fetch stage, the memory stage and the single memory bus; replaces separate instruction/data memories.
- Data port has priority; a starvation guard bounds the fetch wait.
- One outstanding transaction at a time; FSM sequences request, accept and read response.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 3, consecutive DM wins over a waiting IF before IF is forced to win (0 = strict DM priority, no guard).
- TIMEOUT_CYCLES, 64, read-response watchdog limit (used only with ARB_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-high
- i_if_req  in  1  IF read request; held with address until granted
- i_if_addr  in  AW  IF address
- o_if_gnt  out  1  IF request captured this cycle
- o_if_rvalid  out  1  one-cycle pulse, IF read data valid
- o_if_rdata  out  DW  IF read data, held until next IF response
- i_dm_req  in  1  DM request; held with all DM fields until granted
- i_dm_we  in  1  DM write enable
- i_dm_addr  in  AW  DM address
- i_dm_wdata  in  DW  DM write data
- i_dm_be  in  DW/8  DM byte enables
- o_dm_gnt  out  1  DM request captured this cycle
- o_dm_rvalid  out  1  one-cycle pulse, DM read data valid
- o_dm_rdata  out  DW  DM read data, held until next DM response
- o_mem_req  out  1  memory request valid
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  AW  memory address
- o_mem_wdata  out  DW  memory write data
- o_mem_be  out  DW/8  memory byte enables (all ones for IF reads)
- i_mem_ready  in  1  memory accepts the request when o_mem_req & i_mem_ready
- i_mem_rvalid  in  1  read data valid, at least 1 cycle after accept
- i_mem_rdata  in  DW  read data
- o_err  out  1  watchdog-timeout pulse (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, i_reset=1): state IDLE; starve_cnt=0; all outputs 0, including the rdata registers and the captured request registers.
- States: IDLE, REQ, WAIT.
- Winner selection in IDLE:
  - DM wins if i_dm_req, unless i_if_req & STARVE_LIMIT!=0 & starve_cnt==STARVE_LIMIT, in which case IF wins.
  - Otherwise IF wins if i_if_req.
- Grant in IDLE: o_x_gnt is combinational = (state==IDLE) & winner==x. At most one grant per cycle.
  - On grant, the winner's fields are registered (IF: we=0, be=all ones, wdata=0), owner is recorded, and the FSM moves to REQ.
  - Requester may drop or change its request the cycle after grant.
- starve_cnt:
  - Updates only on a grant.
  - Increments (saturating at STARVE_LIMIT) when DM is granted while i_if_req=1.
  - Clears when IF is granted.
  - Holds otherwise.
- REQ: o_mem_req=1 with the registered fields, held stable until i_mem_ready.
  - On accept, a write goes to IDLE; a read goes to WAIT.
  - No grant is possible in REQ or WAIT.
- WAIT: o_mem_req=0. On i_mem_rvalid:
  - i_mem_rdata is registered into the owner's rdata.
  - The owner's rvalid pulses for 1 cycle on the next edge.
  - The FSM returns to IDLE.
  - i_mem_rvalid outside WAIT is ignored.
- Latency:
  - Grant to o_mem_req is 1 cycle. The minimum arbitration cycle for a write is 2 clocks (IDLE, REQ with ready=1).
  - Read data reaches the requester 1 cycle after i_mem_rvalid.
- A new grant may occur in the same cycle the previous owner's rvalid pulses, since the FSM is already in IDLE.
- Simultaneous i_if_req and i_dm_req with starve_cnt<limit: DM is granted; IF stays pending with no grant.
- Reset mid-transaction drops the transaction with no rvalid. A memory response arriving after reset is ignored because the state is IDLE.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry.
  - If it reaches TIMEOUT_CYCLES without i_mem_rvalid, o_err pulses for 1 cycle.
  - The owner's rvalid pulses with rdata=0 and the FSM returns to IDLE.
- Undefined: no counter; WAIT lasts indefinitely; o_err is tied 0.

Test Plan:
- DM write: dm_req, we=1, addr=0x100, wdata=0xCAFEF00D, be=0xF; ready=1 -> dm_gnt in cycle 0; o_mem_req/we/addr/wdata in cycle 1; IDLE in cycle 2; no rvalid.
- IF read: if_req, addr=0x40; ready=1; rvalid 2 cycles after accept with rdata=0x00000013 -> if_rvalid pulses 1 cycle later with if_rdata=0x00000013; dm_rvalid stays 0.
- Contention with STARVE_LIMIT=3: both requests held continuously, DM re-requesting after each grant -> DM granted 3 times, 4th grant goes to IF, starve_cnt returns to 0.
- Backpressure: DM read with i_mem_ready low for 5 cycles -> o_mem_req and fields stable all 5 cycles; accept on cycle 6; no grant to IF during REQ/WAIT.
- Reset mid-WAIT: assert i_reset during a pending IF read, then deliver i_mem_rvalid after release -> no if_rvalid; all outputs 0; next request granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: read accepted, no rvalid -> o_err pulse plus owner rvalid with rdata=0 after 8 WAIT cycles; FSM back in IDLE.
